// File: rtl/button_pkg.sv
// Shared definitions for the debounced button reader.
//   btn_state_e : per-button debounce FSM state encoding
//   NUM_BTN     : number of pmod push-buttons handled
//   LED_*       : bit positions inside the 5-bit LED bank
`timescale 1ns/1ps
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int NUM_BTN    = 2;

  localparam int LED_TOG0   = 0;
  localparam int LED_TOG1   = 1;
  localparam int LED_BOTH   = 2;
  localparam int LED_CNT_LO = 3;

endpackage

// File: rtl/button_toggle_led_debounce_fsm.sv
// debounce_fsm: one button lane. It has a 2-flop synchroniser, an inversion
// to active-high, and a counter-qualified FSM.
//   clk         : system clock
//   rst_btn     : synchronous active-low reset
//   btn_n       : raw button pin, active-low, asynchronous to clk
//   pressed     : high while the FSM sits in PRESSED (decoded from the state flops)
//   press_pulse : registered one-cycle strobe on PRESS_WAIT -> PRESSED
`timescale 1ns/1ps
module debounce_fsm
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic          btn_s;
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          pulse_nxt;

  assign btn_s   = ~sync[1];
  assign cnt_inc = cnt + 1'b1;
  assign pressed = (state == PRESSED);

  // The synchroniser resets to 1 (released), so a button that is held through
  // reset must requalify through PRESS_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      sync        <= 2'b11;
      state       <= RELEASED;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_n};
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= pulse_nxt;
    end
  end

  // The WAIT states exit on the terminal count, so the counter never needs
  // to saturate.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_inc == TERM) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc == TERM) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_toggle_led.sv
// button_toggle_led: debounced reader for the two active-low pmod buttons.
//   clk         : system clock
//   rst_btn     : synchronous active-low reset
//   pmod[1:0]   : raw buttons, active-low, asynchronous
//   led[4:0]    : {press count[1:0], both held, toggle1, toggle0}, registered
//   press_pulse : one-cycle strobe per accepted press, one bit per button
// Optional macro BTN_PRESS_COUNT_EN: when it is defined, led[4:3] counts the
// button-0 presses and wraps from 3 to 0. When it is undefined, led[4:3] is
// tied to 0.
`timescale 1ns/1ps
module button_toggle_led
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic               clk,
  input  logic               rst_btn,
  input  logic [NUM_BTN-1:0] pmod,
  output logic [4:0]         led,
  output logic [NUM_BTN-1:0] press_pulse
);

  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] tog;
  logic               both;
  logic [1:0]         press_cnt;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .btn_n       (pmod),
    .pressed     (pressed),
    .press_pulse (press_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      tog  <= '0;
      both <= 1'b0;
    end else begin
      tog  <= tog ^ press_pulse;
      both <= &pressed;
    end
  end

`ifdef BTN_PRESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_btn)            press_cnt <= 2'd0;
    else if (press_pulse[0]) press_cnt <= press_cnt + 2'd1;
  end
`else
  assign press_cnt = 2'b00;
`endif

  assign led[LED_TOG0]                  = tog[0];
  assign led[LED_TOG1]                  = tog[1];
  assign led[LED_BOTH]                  = both;
  assign led[LED_CNT_LO+1:LED_CNT_LO]   = press_cnt;

endmodule

// File: tb/tb_button_toggle_led.sv
// Randomised and directed bench for button_toggle_led with DEBOUNCE_CYCLES=4.
// The reference model sees each button as a debounced level. That level flips
// once the 2-cycle-delayed input has disagreed with it for DEBOUNCE_CYCLES+1
// consecutive samples. The model pushes the expected outputs for every clock
// edge into a queue, and a monitor process compares them at the falling edge.
`timescale 1ns/1ps
module tb_button_toggle_led;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b0;
  logic [1:0] pmod = 2'b11;
  logic [4:0] led;
  logic [1:0] press_pulse;

  always #5 clk = ~clk;

  button_toggle_led #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .pmod        (pmod),
    .led         (led),
    .press_pulse (press_pulse)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] led;
    logic [1:0] pulse;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  bit [1:0] dly0 = 2'b11, dly1 = 2'b11;  // pmod seen 1 and 2 edges ago
  bit [1:0] deb  = 2'b00;                // accepted level (1 = held)
  int       run[2] = '{0, 0};            // samples disagreeing with deb
  bit [1:0] m_pulse = 2'b00, m_tog = 2'b00, m_cnt = 2'b00;
  bit       m_both = 1'b0;

  task automatic model_edge();
    bit [1:0] seen;
    bit [1:0] np;
    exp_t     e;
    if (!rst_btn) begin
      dly0 = 2'b11; dly1 = 2'b11; deb = 2'b00;
      run[0] = 0; run[1] = 0;
      m_pulse = 2'b00; m_tog = 2'b00; m_cnt = 2'b00; m_both = 1'b0;
    end else begin
      seen   = ~dly1;
      m_tog  = m_tog ^ m_pulse;
`ifdef BTN_PRESS_COUNT_EN
      if (m_pulse[0]) m_cnt = m_cnt + 2'd1;
`endif
      // a button counts as fully held only when it is accepted and no release is pending
      m_both = deb[0] && run[0] == 0 && deb[1] && run[1] == 0;
      np = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (seen[i] != deb[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            deb[i] = seen[i];
            run[i] = 0;
            np[i]  = seen[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      m_pulse = np;
      dly1 = dly0;
      dly0 = pmod;
    end
    e.led   = {m_cnt, m_both, m_tog};
    e.pulse = m_pulse;
    exp_q.push_back(e);
  endtask

  // Inputs stay constant across the edge, and the model runs on that same edge.
  task automatic step(input logic r, input logic [1:0] p);
    rst_btn = r;
    pmod    = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic r, input logic [1:0] p, input int n);
    for (int i = 0; i < n; i++) step(r, p);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e.led) begin
        errors++;
        $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
      end
      checks++;
      if (press_pulse !== e.pulse) begin
        errors++;
        $display("FAIL press_pulse t=%0t got=%b exp=%b", $time, press_pulse, e.pulse);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    // reset while both buttons are held, then both requalify after release
    hold(1'b0, 2'b00, 3);
    hold(1'b1, 2'b00, 10);
    hold(1'b1, 2'b11, 10);
    // clean press, release, press again on button 0
    hold(1'b1, 2'b10, 10);
    hold(1'b1, 2'b11, 10);
    hold(1'b1, 2'b10, 10);
    hold(1'b1, 2'b11, 10);
    // bounce on button 0
    step(1'b1, 2'b10); step(1'b1, 2'b11); step(1'b1, 2'b10); step(1'b1, 2'b11);
    hold(1'b1, 2'b11, 10);
    // both held, then button 1 released
    hold(1'b1, 2'b10, 3);
    hold(1'b1, 2'b00, 10);
    hold(1'b1, 2'b10, 8);
    hold(1'b1, 2'b11, 10);
    // reset mid-debounce
    hold(1'b1, 2'b10, 5);
    hold(1'b0, 2'b10, 2);
    hold(1'b1, 2'b11, 10);
    // five clean presses (press counter wrap)
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 2'b10, 9);
      hold(1'b1, 2'b11, 9);
    end
    // random levels and durations, with an occasional reset
    for (int k = 0; k < 80; k++) begin
      logic       r;
      logic [1:0] p;
      r = ($urandom_range(0, 24) != 0);
      p = 2'($urandom);
      hold(r, p, $urandom_range(1, 9));
    end
    hold(1'b1, 2'b11, 10);
    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_toggle_led.md
# button_toggle_led

Debounced reader for the two active-low pmod push-buttons. It synchronises and debounces each button, then emits one-cycle press pulses. It drives the LED bank with latched toggle states, a debounced both-held indicator and an optional press counter. It sits between the raw pmod pins and the led outputs, replacing direct combinational button-to-LED paths with glitch-free, edge-based behaviour.

## Interface
- DEBOUNCE_CYCLES, 120000: consecutive stable samples required to accept a level change (10 ms at 12 MHz); minimum 1.
- clk  input  1  system clock.
- rst_btn  input  1  reset, synchronous, active-low; sampled on rising clk.
- pmod  input  2  raw buttons, active-low (0 = pressed), asynchronous to clk.
- led  output  5  LED drive, active-high.
- press_pulse  output  2  one-cycle strobe per accepted press, bit i for button i.

## Operation
- Per button: 2-flop synchroniser, then inversion to active-high `btn_s[i]`.
- Per-button FSM, state names RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: btn_s=1 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn_s=1 → counter++; counter reaches DEBOUNCE_CYCLES → PRESSED. btn_s=0 (bounce) → RELEASED, counter cleared.
  - PRESSED: btn_s=0 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn_s=0 → counter++; counter reaches DEBOUNCE_CYCLES → RELEASED. btn_s=1 → PRESSED, counter cleared.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). Saturation is not required because the FSM leaves the WAIT states at the terminal count.
- press_pulse[i] is high for exactly the one cycle of the PRESS_WAIT→PRESSED transition. Release generates no pulse.
- led[1:0]: toggle flops. led[i] inverts on each press_pulse[i].
- led[2]: registered AND of (state0==PRESSED) and (state1==PRESSED).
- led[4:3]: press counter (see Configuration).
- Simultaneous presses on both buttons are handled independently. Both pulses may assert in the same cycle.

## Timing
- Reset (rst_btn=0 at clk edge):
  - synchroniser flops reset to 1 (released);
  - FSMs reset to RELEASED and counters to 0;
  - led = 5'b00000 and press_pulse = 2'b00 on the following cycle.
- Reset asserted mid-debounce or mid-press aborts the operation. No pulse is emitted. A button still held after reset must be re-qualified through PRESS_WAIT, which yields one pulse after DEBOUNCE_CYCLES+2 cycles.
- Latency: stable pmod falling edge sampled at cycle 0 → press_pulse high at cycle DEBOUNCE_CYCLES+2.
  - led[1:0] toggles at cycle DEBOUNCE_CYCLES+3.
  - led[2] rises at cycle DEBOUNCE_CYCLES+3 after the second button reaches PRESSED.
- Release latency is DEBOUNCE_CYCLES+2 cycles to RELEASED. led[2] falls one cycle after leaving PRESSED, i.e. at the RELEASE_WAIT entry plus 1.
- All outputs are registered. No combinational path runs from pmod to any output.

## Configuration
- BTN_PRESS_COUNT_EN defined: led[4:3] is a 2-bit counter incremented on each press_pulse[0]. It wraps 3→0, resets to 0, and is registered, updating the cycle after the pulse.
- Undefined: led[4:3] is tied to 2'b00 and no counter logic is generated.

## Structure
- Package button_pkg holds:
  - FSM state encoding: RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3;
  - NUM_BTN=2 constant;
  - LED bit-index constants: LED_TOG0=0, LED_TOG1=1, LED_BOTH=2, LED_CNT_LO=3.
- Sub-module debounce_fsm, instantiated once per button (synchroniser + counter + FSM). Outputs: `pressed` level and `press_pulse` strobe. The top level holds the toggle flops, the AND register and the optional counter.

## Test plan
Benches run with DEBOUNCE_CYCLES=4.
- Reset check: hold rst_btn=0 for 3 cycles with pmod=2'b00 → led=0 and press_pulse=0 throughout. After release with pmod still 2'b00, both pulses fire 6 cycles later.
- Clean press: pmod[0] 1→0 at cycle 0 and held → press_pulse[0] high only at cycle 6, led[0]=1 from cycle 7. Release and re-press → led[0]=0.
- Bounce: pmod[0] toggles 0,1,0,1 on consecutive cycles, then stays 1 → no press_pulse and led unchanged.
- Both held: press pmod[0], then pmod[1] 3 cycles later → led[2]=1 from cycle 10. Release pmod[1] → led[2]=0 one cycle after its FSM leaves PRESSED.
- Reset mid-debounce: assert rst_btn at cycle 3 of PRESS_WAIT → no pulse and led=0.
- Count wrap (BTN_PRESS_COUNT_EN defined): 5 clean presses on button 0 → led[4:3] sequence 1,2,3,0,1. With the macro undefined → led[4:3]=0 throughout.
